// File: rtl/matmul_pkg.sv
// Shared types for the matmul sequencer: FSM state encoding, default K_MAX
// and a saturating 32-bit increment used by the optional performance counter.
package matmul_pkg;

    localparam int MATMUL_K_MAX_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_WB,
        ST_DONE
    } state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/matmul_ctrl.sv
// Systolic-array matmul sequencer: operand load, skew drain, row writeback.
// Optional busy-cycle counter on perf_cycles when MATMUL_CTRL_PERF_EN is defined.
module matmul_ctrl
    import matmul_pkg::*;
#(
    parameter int NUM_ROWS = 2,
    parameter int NUM_COLS = 2,
    parameter int K_MAX    = MATMUL_K_MAX_DEFAULT,
    parameter int K_WIDTH  = $clog2(K_MAX + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [K_WIDTH-1:0]          k_len,
    input  logic                        abort,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic                        op_rd_en,
    output logic [K_WIDTH-1:0]          op_rd_addr,
    output logic                        arr_clear,
    output logic                        arr_en,
    output logic                        arr_zero,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [$clog2(NUM_ROWS)-1:0] res_row,
    output logic [31:0]                 perf_cycles
);

    localparam int DW = $clog2(NUM_ROWS + NUM_COLS);
    localparam int RW = $clog2(NUM_ROWS);

    state_t             state;
    logic [K_WIDTH-1:0] k_reg;
    logic [DW-1:0]      drain_cnt;

    logic k_ok;
    logic accept;
    logic wb_last;

    assign k_ok    = (k_len != '0) && (k_len <= K_WIDTH'(K_MAX));
    assign accept  = (state == ST_IDLE) && start && k_ok;
    assign wb_last = (state == ST_WB) && !abort && res_ready &&
                     (res_row == RW'(NUM_ROWS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            k_reg      <= '0;
            drain_cnt  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            op_rd_en   <= 1'b0;
            op_rd_addr <= '0;
            arr_clear  <= 1'b0;
            arr_en     <= 1'b0;
            arr_zero   <= 1'b1;
            res_valid  <= 1'b0;
            res_row    <= '0;
        end else begin
            done      <= 1'b0;
            err       <= 1'b0;
            arr_clear <= 1'b0;
            // Buffer data arrives one cycle after the read, so zeros are fed
            // whenever the previous cycle issued no read.
            arr_zero  <= ~op_rd_en;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (k_ok) begin
                            k_reg      <= k_len;
                            state      <= ST_LOAD;
                            busy       <= 1'b1;
                            op_rd_en   <= 1'b1;
                            op_rd_addr <= '0;
                            arr_clear  <= 1'b1;
                            arr_en     <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_LOAD, ST_DRAIN, ST_WB: begin
                    if (abort) begin
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        op_rd_en   <= 1'b0;
                        op_rd_addr <= '0;
                        arr_en     <= 1'b0;
                        res_valid  <= 1'b0;
                        res_row    <= '0;
                    end else if (state == ST_LOAD) begin
                        if (op_rd_addr == k_reg - K_WIDTH'(1)) begin
                            state      <= ST_DRAIN;
                            op_rd_en   <= 1'b0;
                            op_rd_addr <= '0;
                            drain_cnt  <= '0;
                        end else begin
                            op_rd_addr <= op_rd_addr + K_WIDTH'(1);
                        end
                    end else if (state == ST_DRAIN) begin
                        if (drain_cnt == DW'(NUM_ROWS + NUM_COLS - 1)) begin
                            state     <= ST_WB;
                            arr_en    <= 1'b0;
                            res_valid <= 1'b1;
                            res_row   <= '0;
                        end else begin
                            drain_cnt <= drain_cnt + DW'(1);
                        end
                    end else if (res_ready) begin
                        if (wb_last) begin
                            state     <= ST_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            res_valid <= 1'b0;
                            res_row   <= '0;
                        end else begin
                            res_row <= res_row + RW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MATMUL_CTRL_PERF_EN
    logic [31:0] perf_cnt;

    // The final WB cycle is still busy, so it is folded into the published value.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cnt    <= '0;
            perf_cycles <= '0;
        end else begin
            if (accept) begin
                perf_cnt <= '0;
            end else if (busy) begin
                perf_cnt <= sat_inc(perf_cnt);
            end
            if (wb_last) begin
                perf_cycles <= sat_inc(perf_cnt);
            end
        end
    end
`else
    assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_matmul_ctrl.sv
// Self-checking bench for matmul_ctrl: per-cycle trace model of each job plus
// literal checks on done latency, perf_cycles and reset state.
module tb_matmul_ctrl;

    localparam int NR = 2;
    localparam int NC = 2;
    localparam int KW = 5;
    localparam int VW = 46;
`ifdef MATMUL_CTRL_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    // Handshake: a writeback row transfers on any rising edge where
    // res_valid and res_ready are both high; res_valid stays high until then.

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [KW-1:0] k_len = '0;
    logic          abort = 1'b0;
    logic          busy, done, err, op_rd_en;
    logic [KW-1:0] op_rd_addr;
    logic          arr_clear, arr_en, arr_zero, res_valid;
    logic          res_ready = 1'b1;
    logic [0:0]    res_row;
    logic [31:0]   perf_cycles;

    matmul_ctrl #(.NUM_ROWS(NR), .NUM_COLS(NC), .K_MAX(16)) dut (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len), .abort(abort),
        .busy(busy), .done(done), .err(err), .op_rd_en(op_rd_en),
        .op_rd_addr(op_rd_addr), .arr_clear(arr_clear), .arr_en(arr_en),
        .arr_zero(arr_zero), .res_valid(res_valid), .res_ready(res_ready),
        .res_row(res_row), .perf_cycles(perf_cycles)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cyc = 0;
    int last_done_cyc = -1;
    int exp_perf_idle = 0;
    bit chk_en = 1'b0;

    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] act;

    assign act = {busy, done, err, op_rd_en, op_rd_addr, arr_clear, arr_en,
                  arr_zero, res_valid, res_row, perf_cycles};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [VW-1:0] mk(bit b, bit d, bit e, bit r, int a,
                                          bit c, bit en, bit z, bit v,
                                          int row, int perf);
        return {b, d, e, r, 5'(a), c, en, z, v, 1'(row), 32'(perf)};
    endfunction

    task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, a, e, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected output trace of one accepted job, starting with the start cycle.
    task automatic push_job(input int k, input int stall);
        int p_old;
        int p_new;
        p_old = exp_perf_idle;
        p_new = PERF ? (k + 2 * NR + NC + stall) : 0;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, p_old));
        for (int i = 0; i < k; i++)
            exp_q.push_back(mk(1, 0, 0, 1, i, i == 0, 1, i == 0, 0, 0, p_old));
        for (int j = 0; j < NR + NC; j++)
            exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 1, j != 0, 0, 0, p_old));
        for (int r = 0; r < NR; r++)
            for (int s = 0; s < ((r == 0) ? stall + 1 : 1); s++)
                exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, r, p_old));
        exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, p_new));
    endtask

    always @(negedge clk) begin
        logic [VW-1:0] e;
        if (chk_en) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, exp_perf_idle);
            if (e[44]) exp_perf_idle = int'(e[31:0]);
            if (done) last_done_cyc = cyc;
            chk("cycle_outputs", 64'(act), 64'(e));
        end
    end

    task automatic run_job(input int k, input int stall, input int st_at,
                           input int ab_at, input int rs_at);
        int len;
        len = k + 2 * NR + NC + stall + 1;
        last_done_cyc = -1;
        push_job(k, stall);
        start_cyc = cyc;
        for (int t = 0; t <= len + 2; t++) begin
            start     = (t == 0) || (t == st_at);
            k_len     = (t == 0) ? KW'(k) : KW'(3);
            res_ready = !(t >= k + NR + NC + 1 && t < k + NR + NC + 1 + stall);
            abort     = (t == ab_at);
            reset     = (t == rs_at);
            tick();
            if (t == ab_at || t == rs_at) begin
                exp_q.delete();
                if (t == rs_at) exp_perf_idle = 0;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        reset = 1'b0;
        res_ready = 1'b1;
    endtask

    task automatic run_err(input int k);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, exp_perf_idle));
        exp_q.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, exp_perf_idle));
        start = 1'b1;
        k_len = KW'(k);
        tick();
        start = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        chk_en = 1'b1;
        chk("reset_state", 64'(act), 64'({14'h0004, 32'd0}));
        tick();

        run_job(4, 0, -1, -1, -1);
        chk("done_latency_k4", 64'(last_done_cyc - start_cyc), 64'(11));
        chk("perf_k4", 64'(perf_cycles), 64'(PERF ? 10 : 0));

        run_err(0);
        run_err(17);

        run_job(4, 3, -1, -1, -1);
        chk("done_latency_stall3", 64'(last_done_cyc - start_cyc), 64'(14));
        chk("perf_stall3", 64'(perf_cycles), 64'(PERF ? 13 : 0));

        run_job(4, 0, -1, 6, -1);
        chk("abort_no_done", 64'(last_done_cyc), 64'(-1));
        chk("perf_after_abort", 64'(perf_cycles), 64'(PERF ? 13 : 0));

        run_job(1, 0, -1, -1, -1);
        chk("done_latency_k1", 64'(last_done_cyc - start_cyc), 64'(8));

        run_job(4, 0, -1, -1, 2);
        chk("reset_no_done", 64'(last_done_cyc), 64'(-1));
        chk("perf_after_reset", 64'(perf_cycles), 64'(0));

        run_job(4, 0, 2, -1, -1);
        chk("done_latency_busy_start", 64'(last_done_cyc - start_cyc), 64'(11));

        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (2) tick();

        run_job(16, 0, -1, -1, -1);
        chk("done_latency_k16", 64'(last_done_cyc - start_cyc), 64'(23));
        chk("perf_k16", 64'(perf_cycles), 64'(PERF ? 22 : 0));

        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/matmul_ctrl.md
MATMUL_CTRL -- requirements
Module: matmul_ctrl

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 2: systolic array rows (result rows).
REQ-002 SHALL have parameter NUM_COLS, default 2: systolic array columns.
REQ-003 SHALL have parameter K_MAX, default 16: maximum inner dimension.
REQ-004 SHALL have parameter K_WIDTH, default $clog2(K_MAX+1): k_len width.
REQ-005 SHALL use one clock and a synchronous active-high reset, with ports in this order: clk (in, 1, single clock, all logic on rising edge); reset (in, 1, synchronous, active-high).
REQ-006 SHALL have port start (in, 1): job request, sampled in IDLE only.
REQ-007 SHALL have port k_len (in, K_WIDTH): inner dimension, sampled with start.
REQ-008 SHALL have port abort (in, 1): cancel the running job.
REQ-009 SHALL have port busy (out, 1): job in progress.
REQ-010 SHALL have port done (out, 1): one-cycle job-complete pulse.
REQ-011 SHALL have port err (out, 1): one-cycle pulse for an illegal k_len.
REQ-012 SHALL have ports op_rd_en (out, 1) and op_rd_addr (out, K_WIDTH): operand buffer read; data returns 1 cycle later.
REQ-013 SHALL have ports arr_clear, arr_en and arr_zero (out, 1 each): array accumulator clear, array step enable, and feed zeros instead of buffer data.
REQ-014 SHALL have ports res_valid (out, 1), res_ready (in, 1) and res_row (out, $clog2(NUM_ROWS)): result row writeback handshake.
REQ-015 SHALL have port perf_cycles (out, 32): busy-cycle count of the last job.

Function
REQ-016 SHALL implement states IDLE, LOAD, DRAIN, WB, DONE.
REQ-017 SHALL, in IDLE with start=1 and 1<=k_len<=K_MAX, latch k_len and enter LOAD on the next cycle.
REQ-018 SHALL, in IDLE with start=1 and k_len==0 or k_len>K_MAX, pulse err the next cycle and remain IDLE.
REQ-019 SHALL ignore start in every state except IDLE.
REQ-020 SHALL hold LOAD for exactly k_len cycles, with op_rd_en=1 and op_rd_addr counting 0..k_len-1.
REQ-021 SHALL assert arr_clear only in the first LOAD cycle; clear takes priority over the array step.
REQ-022 SHALL assert arr_en in every LOAD and DRAIN cycle; arr_zero SHALL equal op_rd_en delayed by one cycle, inverted.
REQ-023 SHALL hold DRAIN for exactly NUM_ROWS+NUM_COLS cycles (1 read latency plus NUM_ROWS+NUM_COLS-1 skew).
REQ-024 SHALL, in WB, hold res_valid=1 with res_row starting at 0, advancing on res_valid&res_ready, and SHALL hold res_row stable while res_ready=0.
REQ-025 SHALL, on the handshake of row NUM_ROWS-1, enter DONE; DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-026 SHALL drive busy=1 in LOAD, DRAIN and WB, and busy=0 in IDLE and DONE.
REQ-027 SHALL, with res_ready held at 1, assert done exactly k_len+2*NUM_ROWS+NUM_COLS+1 cycles after the start cycle.
REQ-028 SHALL, when abort=1 in LOAD, DRAIN or WB, enter IDLE next cycle with no done pulse and res_valid=0; abort SHALL be ignored in IDLE and DONE.
REQ-029 SHALL give abort priority over start when both are high in the same cycle.

Reset
REQ-030 SHALL, on reset, enter IDLE with busy, done, err, op_rd_en, op_rd_addr, arr_clear, arr_en and res_valid at 0, res_row at 0, arr_zero at 1 and perf_cycles at 0.
REQ-031 SHALL, on reset mid-job, discard the job with no done pulse.

Configuration
REQ-032 SHALL, with macro MATMUL_CTRL_PERF_EN defined, count busy cycles with a 32-bit saturating counter, zero it when a job is accepted, and update perf_cycles at DONE (k_len+2*NUM_ROWS+NUM_COLS); an aborted job SHALL leave perf_cycles unchanged.
REQ-033 SHALL, without MATMUL_CTRL_PERF_EN, tie perf_cycles to 0 and include no counter logic.

Structure
REQ-034 SHALL put the state enum and K_MAX default in shared package matmul_pkg.
REQ-035 SHALL be a single module with no sub-modules; the counters are inline.

Verification
REQ-036 SHALL cover: 2x2, start with k_len=4, res_ready=1 -> LOAD cycles 1..4 with addr 0..3, DRAIN 4 cycles, res_row 0 then 1, done at cycle 11, perf_cycles=10 (PERF_EN).
REQ-037 SHALL cover: start with k_len=0, then with k_len=17 -> err pulse each time, busy stays 0, no op_rd_en.
REQ-038 SHALL cover: res_ready low for 3 cycles in WB row 0 -> res_valid held, res_row=0 stable, done delayed by 3 cycles.
REQ-039 SHALL cover: abort in 2nd DRAIN cycle -> IDLE next cycle, no done; a new start with k_len=1 completes normally.
REQ-040 SHALL cover: reset asserted during LOAD -> all outputs at reset values next cycle; start during busy -> ignored, op_rd_addr sequence unaffected.
REQ-041 SHALL cover: arr_zero check -> 0 exactly in LOAD cycles 2..k_len and the first DRAIN cycle, 1 otherwise.
